iq_offset_normalizer: RTL and testbench

Parametrised multi-channel normalizer between the I/Q accumulator and the neural-network input stage. Each channel adds a signed offset to the accumulated sample, arithmetically right-shifts by a runtime shift amount and saturates to the NN input width. Offset and shift are per-channel and runtime-programmable. A built-in calibration mode measures the per-channel minimum over a window and loads offset = −minimum. It emits an aligned output-valid and a single-cycle NN start trigger per burst.

---
 rtl/nn_norm_pkg.sv | 15 +
 rtl/iq_offset_normalizer_if.sv | 32 +++
 rtl/norm_lane.sv | 69 ++++++
 rtl/iq_offset_normalizer.sv | 156 +++++++++++++++
 tb/tb_iq_offset_normalizer.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/nn_norm_pkg.sv
// Shared defaults and FSM state type for the I/Q offset normalizer.
package nn_norm_pkg;

  localparam int unsigned DefInW    = 32;
  localparam int unsigned DefOutW   = 18;
  localparam int          DefOffset = 262143;
  localparam int unsigned DefShift  = 7;

  typedef enum logic [1:0] {
    StRun,
    StCal,
    StApply
  } norm_state_e;

endpackage

// File: rtl/iq_offset_normalizer_if.sv
// Sample-in / normalized-out bus between the I/Q accumulator and the NN input stage.
interface iq_offset_normalizer_if
  import nn_norm_pkg::*;
#(
  parameter int unsigned NCH   = 2,
  parameter int unsigned IN_W  = DefInW,
  parameter int unsigned OUT_W = DefOutW
) ();

  logic                   in_valid;
  logic [NCH*IN_W-1:0]    in_data;
  logic [NCH*OUT_W-1:0]   out_data;
  logic                   out_valid;
  logic                   nn_start;

  modport master (
    output in_valid,
    output in_data,
    input  out_data,
    input  out_valid,
    input  nn_start
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_data,
    output out_valid,
    output nn_start
  );

endinterface

// File: rtl/norm_lane.sv
// One channel: register input with its config, add offset, arithmetic shift, saturate.
module norm_lane #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 18,
  parameter int unsigned SH_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_in,
  input  logic                    ld_add,
  input  logic                    ld_out,
  input  logic signed [IN_W-1:0]  x,
  input  logic signed [IN_W-1:0]  offset,
  input  logic [SH_W-1:0]         shift,
  output logic signed [OUT_W-1:0] y,
  output logic                    sat_next
);

  localparam logic signed [IN_W:0] YMax = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] YMin = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0]  x_q, off_q;
  logic [SH_W-1:0]         sh1_q, sh2_q;
  logic signed [IN_W:0]    sum_d, sum_q, shifted;
  logic signed [OUT_W-1:0] y_d, y_q;

  // Config travels with the sample so a same-cycle write never touches it.
  assign sum_d = {x_q[IN_W-1], x_q} + {off_q[IN_W-1], off_q};

  always_comb begin
    shifted  = sum_q >>> sh2_q;
    y_d      = shifted[OUT_W-1:0];
    sat_next = 1'b0;
    if (shifted > YMax) begin
      y_d      = YMax[OUT_W-1:0];
      sat_next = 1'b1;
    end else if (shifted < YMin) begin
      y_d      = YMin[OUT_W-1:0];
      sat_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      off_q <= '0;
      sh1_q <= '0;
      sum_q <= '0;
      sh2_q <= '0;
      y_q   <= '0;
    end else begin
      if (ld_in) begin
        x_q   <= x;
        off_q <= offset;
        sh1_q <= shift;
      end
      if (ld_add) begin
        sum_q <= sum_d;
        sh2_q <= sh1_q;
      end
      if (ld_out) begin
        y_q <= y_d;
      end
    end
  end

  assign y = y_q;

endmodule

// File: rtl/iq_offset_normalizer.sv
// Multi-channel offset/shift/saturate normalizer with min-based offset calibration.
module iq_offset_normalizer
  import nn_norm_pkg::*;
#(
  parameter int unsigned IN_W       = DefInW,
  parameter int unsigned OUT_W      = DefOutW,
  parameter int unsigned NCH        = 2,
  parameter int unsigned SH_W       = 5,
  parameter int          OFFSET_DEF = DefOffset,
  parameter int unsigned SHIFT_DEF  = DefShift,
  parameter int unsigned CAL_LOG2   = 4,
  localparam int unsigned CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  iq_offset_normalizer_if.slave   bus,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [IN_W-1:0]         cfg_offset,
  input  logic [SH_W-1:0]         cfg_shift,
  input  logic                    cal_start,
  output logic                    cal_busy,
  output logic                    sat_flag
);

  localparam logic signed [IN_W-1:0] MaxPos  = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MinNeg  = {1'b1, {(IN_W-1){1'b0}}};
  localparam logic [CAL_LOG2:0]      CalLast = (CAL_LOG2+1)'((1 << CAL_LOG2) - 1);

  norm_state_e state_q, state_d;

  logic signed [IN_W-1:0]  offset_q [NCH];
  logic signed [IN_W-1:0]  offset_d [NCH];
  logic [SH_W-1:0]         shift_q  [NCH];
  logic [SH_W-1:0]         shift_d  [NCH];
  logic signed [IN_W-1:0]  min_q    [NCH];
  logic signed [IN_W-1:0]  min_d    [NCH];
  logic signed [IN_W-1:0]  x_ch     [NCH];
  logic signed [OUT_W-1:0] y_ch     [NCH];
  logic [NCH-1:0]          lane_sat;

  logic [CAL_LOG2:0] cnt_q, cnt_d;
  logic v1_q, v2_q, out_valid_q, nn_start_q, sat_flag_q;
  logic v1_d, v2_d, out_valid_d, nn_start_d, sat_flag_d;
  logic run, cal_go, flush;

  // -min overflows only for the most negative value; clamp that to max positive.
  function automatic logic signed [IN_W-1:0] neg_sat(input logic signed [IN_W-1:0] v);
    if (v == MinNeg) return MaxPos;
    return -v;
  endfunction

  assign run    = (state_q == StRun);
  assign cal_go = run & cal_start;
  // Samples in flight when calibration begins, and any taken during it, never emerge.
  assign flush  = cal_go | ~run;

  assign v1_d        = bus.in_valid & ~flush;
  assign v2_d        = v1_q & ~flush;
  assign out_valid_d = v2_q & ~flush;
  assign nn_start_d  = out_valid_d & ~out_valid_q;
  assign sat_flag_d  = cal_go ? 1'b0 : (sat_flag_q | (out_valid_d & (|lane_sat)));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    offset_d = offset_q;
    shift_d  = shift_q;
    min_d    = min_q;
    unique case (state_q)
      StRun: begin
        if (cfg_we && (int'(cfg_ch) < int'(NCH))) begin
          offset_d[cfg_ch] = cfg_offset;
          shift_d[cfg_ch]  = cfg_shift;
        end
        if (cal_start) begin
          state_d = StCal;
          cnt_d   = '0;
          for (int ch = 0; ch < NCH; ch++) min_d[ch] = MaxPos;
        end
      end
      StCal: begin
        if (bus.in_valid) begin
          for (int ch = 0; ch < NCH; ch++) begin
            if (x_ch[ch] < min_q[ch]) min_d[ch] = x_ch[ch];
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CalLast) state_d = StApply;
        end
      end
      StApply: begin
        for (int ch = 0; ch < NCH; ch++) offset_d[ch] = neg_sat(min_q[ch]);
        state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      nn_start_q  <= 1'b0;
      sat_flag_q  <= 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
        offset_q[ch] <= IN_W'(OFFSET_DEF);
        shift_q[ch]  <= SH_W'(SHIFT_DEF);
        min_q[ch]    <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      out_valid_q <= out_valid_d;
      nn_start_q  <= nn_start_d;
      sat_flag_q  <= sat_flag_d;
      offset_q    <= offset_d;
      shift_q     <= shift_d;
      min_q       <= min_d;
    end
  end

  // Channel 0 sits in the most-significant slice of each packed bus.
  for (genvar ch = 0; ch < NCH; ch++) begin : g_lane
    assign x_ch[ch] = bus.in_data[(NCH-ch)*IN_W-1 -: IN_W];

    norm_lane #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SH_W  (SH_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .ld_in    (v1_d),
      .ld_add   (v1_q),
      .ld_out   (out_valid_d),
      .x        (x_ch[ch]),
      .offset   (offset_q[ch]),
      .shift    (shift_q[ch]),
      .y        (y_ch[ch]),
      .sat_next (lane_sat[ch])
    );

    assign bus.out_data[(NCH-ch)*OUT_W-1 -: OUT_W] = y_ch[ch];
  end

  assign bus.out_valid = out_valid_q;
  assign bus.nn_start  = nn_start_q;
  assign cal_busy      = ~run;
  assign sat_flag      = sat_flag_q;

endmodule

// File: tb/tb_iq_offset_normalizer.sv
// Directed bench for iq_offset_normalizer: defaults, saturation, config, calibration, bursts.
module tb_iq_offset_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic        cfg_ch;
  logic [31:0] cfg_offset;
  logic [4:0]  cfg_shift;
  logic        cal_start;
  logic        cal_busy;
  logic        sat_flag;

  int n_tests = 0;
  int n_fail  = 0;

  iq_offset_normalizer_if #(.NCH(2), .IN_W(32), .OUT_W(18)) bus ();

  iq_offset_normalizer #(.CAL_LOG2(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_offset (cfg_offset),
    .cfg_shift  (cfg_shift),
    .cal_start  (cal_start),
    .cal_busy   (cal_busy),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  logic signed [17:0] y0, y1;
  assign y0 = bus.out_data[35:18];
  assign y1 = bus.out_data[17:0];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int d0, input int d1);
    bus.in_valid = v;
    bus.in_data  = {d0, d1};
  endtask

  task automatic cfg(input logic we, input logic ch, input int off, input int sh);
    cfg_we     = we;
    cfg_ch     = ch;
    cfg_offset = off;
    cfg_shift  = sh[4:0];
  endtask

  logic [11:0] pin;
  logic        exp_ov, exp_nn, prev_ov;

  initial begin
    rst       = 1'b1;
    cal_start = 1'b0;
    cfg(1'b0, 1'b0, 0, 0);
    drive(1'b0, 0, 0);
    tick();
    tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_nn_start", bus.nn_start, 0);
    chk("rst_cal_busy", cal_busy, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_ch0", y0, 0);
    chk("rst_ch1", y1, 0);
    rst = 1'b0;

    // Default offset/shift: (1000+262143)>>>7 = 2055, (-262143+262143)>>>7 = 0
    drive(1'b1, 1000, -262143);
    tick();
    drive(1'b0, 0, 0);
    tick();
    tick();
    chk("dflt_ch0", y0, 2055);
    chk("dflt_ch1", y1, 0);
    chk("dflt_valid", bus.out_valid, 1);
    chk("dflt_nn_start", bus.nn_start, 1);
    tick();
    chk("dflt_valid_drop", bus.out_valid, 0);
    chk("dflt_nn_drop", bus.nn_start, 0);
    chk("dflt_no_sat", sat_flag, 0);

    // Saturation on both rails, then sticky flag with zero inputs (0+262143)>>>7 = 2047
    drive(1'b1, 1 << 30, int'(32'h8000_0000));
    tick();
    drive(1'b1, 0, 0);
    tick();
    drive(1'b0, 0, 0);
    tick();
    chk("sat_ch0", y0, 131071);
    chk("sat_ch1", y1, -131072);
    chk("sat_flag_set", sat_flag, 1);
    tick();
    chk("zero_ch0", y0, 2047);
    chk("zero_ch1", y1, 2047);
    tick();
    chk("sat_flag_sticky", sat_flag, 1);

    // ch1 offset=0 shift=0 written alongside a sample: that sample keeps old config
    cfg(1'b1, 1'b1, 0, 0);
    drive(1'b1, 1000, 5);
    tick();
    cfg(1'b0, 1'b0, 0, 0);
    tick();
    drive(1'b0, 0, 0);
    tick();
    chk("cfg_same_cycle_ch1", y1, 2048);
    chk("cfg_same_cycle_ch0", y0, 2055);
    chk("cfg_nn_start", bus.nn_start, 1);
    tick();
    chk("cfg_new_ch1", y1, 5);
    chk("cfg_new_ch0", y0, 2055);
    chk("cfg_burst_valid", bus.out_valid, 1);
    chk("cfg_burst_nn", bus.nn_start, 0);

    // Calibration: ch0 shift 0; sample on cal_start cycle (-1000) is not counted
    cfg(1'b1, 1'b0, 0, 0);
    tick();
    cfg(1'b0, 1'b0, 0, 0);
    drive(1'b1, 500, 7);
    tick();
    drive(1'b1, -1000, 7);
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    chk("cal_busy", cal_busy, 1);
    chk("cal_clears_sat", sat_flag, 0);
    chk("cal_valid_low0", bus.out_valid, 0);
    drive(1'b1, -50, 7);
    tick();
    chk("cal_valid_low1", bus.out_valid, 0);
    drive(1'b0, 0, 0);
    tick();
    chk("cal_valid_low2", bus.out_valid, 0);
    drive(1'b1, -20, 7);
    tick();
    drive(1'b1, -80, 7);
    tick();
    chk("cal_valid_low3", bus.out_valid, 0);
    drive(1'b0, 0, 0);
    tick();
    drive(1'b1, 10, 7);
    tick();
    chk("cal_apply_busy", cal_busy, 1);
    drive(1'b0, 0, 0);
    tick();
    chk("cal_done_busy", cal_busy, 0);
    chk("cal_valid_low4", bus.out_valid, 0);
    drive(1'b1, -80, 7);
    tick();
    drive(1'b1, -50, 7);
    tick();
    drive(1'b0, 0, 0);
    tick();
    chk("cal_ch0_min", y0, 0);
    chk("cal_ch1_min", y1, 0);
    chk("cal_out_valid", bus.out_valid, 1);
    tick();
    chk("cal_ch0_off80", y0, 30);
    chk("cal_ch1_off7", y1, 0);

    // Reset in the middle of calibration restores defaults
    tick();
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    drive(1'b1, -5, -5);
    tick();
    drive(1'b1, -6, -6);
    tick();
    drive(1'b0, 0, 0);
    chk("midcal_busy", cal_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midcal_rst_busy", cal_busy, 0);
    chk("midcal_rst_out", y0, 0);
    chk("midcal_rst_sat", sat_flag, 0);
    drive(1'b1, 1000, -262143);
    tick();
    drive(1'b0, 0, 0);
    tick();
    tick();
    chk("post_rst_ch0", y0, 2055);
    chk("post_rst_ch1", y1, 0);
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_nn", bus.nn_start, 1);
    tick();

    // Bursts of 3 and 2 separated by 2 idle cycles; outputs trail inputs by 3
    pin     = 12'b0000_0110_0111;
    prev_ov = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_ov = (i >= 3) ? pin[i-3] : 1'b0;
      exp_nn = exp_ov & ~prev_ov;
      chk($sformatf("burst_valid_%0d", i), bus.out_valid, exp_ov);
      chk($sformatf("burst_nn_%0d", i), bus.nn_start, exp_nn);
      prev_ov = exp_ov;
      drive(pin[i], 0, 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
